// File: rtl/grf_pkg.sv
// Shared constants and types for the multi-port general register file.
// Holds default widths, the hardwired zero address and the trace record.
package grf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_ADDR  = 0;
  localparam int PC_W       = 32;

  typedef struct packed {
    logic                  valid;
    logic [PC_W-1:0]       pc;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } trc_t;

endpackage

// File: rtl/grf_scoreboard.sv
// Busy-bit scoreboard: issue sets, effective write clears, issue wins.
// Ports: clk, reset_n, iss_valid/iss_addr, wr0/wa0, wr1/wa1, rd_addr -> rd_busy.
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     wr0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic                     wr1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy
);

  localparam int DEPTH = 2**ADDR_W;
  localparam bit ZR = (ZERO_REG != 0);
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_ADDR);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             iss_eff;

  assign iss_eff = iss_valid && !(ZR && iss_addr == ZA);

  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (iss_eff && iss_addr == ADDR_W'(i))
        busy_d[i] = 1'b1;
      else if ((wr0 && wa0 == ADDR_W'(i)) ||
               (wr1 && wa1 == ADDR_W'(i)))
        busy_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_bz
    logic [ADDR_W-1:0] a;
    logic              hit;
    assign a   = rd_addr[k*ADDR_W +: ADDR_W];
    assign hit = (wr0 && wa0 == a) || (wr1 && wa1 == a);
    // A write landing this cycle retires the producer early.
    assign rd_busy[k] = busy_q[a] && !hit && !(ZR && a == ZA);
  end

endmodule

// File: rtl/grf_mp.sv
// Multi-port register file with write-through bypass, busy scoreboard, trace.
// Ports: rd_addr->rd_data/rd_busy, write ports 0/1 (1 wins), issue, trc_*.
module grf_mp
  import grf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic [PC_W-1:0]          wpc0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic [PC_W-1:0]          wpc1,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [1:0]               trc_valid,
  output logic [2*PC_W-1:0]        trc_pc,
  output logic [2*ADDR_W-1:0]      trc_addr,
  output logic [2*DATA_W-1:0]      trc_data
);

  localparam int DEPTH = 2**ADDR_W;
  localparam bit ZR = (ZERO_REG != 0);
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_ADDR);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              eff0;
  logic              eff1;

  logic [1:0]             tv_q;
  logic [1:0][PC_W-1:0]   pc_q;
  logic [1:0][ADDR_W-1:0] ad_q;
  logic [1:0][DATA_W-1:0] dt_q;

  assign eff0 = we0 && !(ZR && wa0 == ZA);
  assign eff1 = we1 && !(ZR && wa1 == ZA);

  // Port 1 assigned last so it wins a same-address collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (eff0) mem[wa0] <= wd0;
      if (eff1) mem[wa1] <= wd1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    assign a = rd_addr[k*ADDR_W +: ADDR_W];
    always_comb begin
      d = mem[a];
      if (ZR && a == ZA)        d = '0;
      else if (eff1 && wa1 == a) d = wd1;
      else if (eff0 && wa0 == a) d = wd0;
    end
    assign rd_data[k*DATA_W +: DATA_W] = d;
  end

  grf_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .reset_n  (reset_n),
    .iss_valid(iss_valid),
    .iss_addr (iss_addr),
    .wr0      (eff0),
    .wa0      (wa0),
    .wr1      (eff1),
    .wa1      (wa1),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy)
  );

  // Lanes hold their last payload; only valid pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tv_q <= '0;
      pc_q <= '0;
      ad_q <= '0;
      dt_q <= '0;
    end else begin
      tv_q <= {eff1, eff0};
      if (eff0) begin
        pc_q[0] <= wpc0;
        ad_q[0] <= wa0;
        dt_q[0] <= wd0;
      end
      if (eff1) begin
        pc_q[1] <= wpc1;
        ad_q[1] <= wa1;
        dt_q[1] <= wd1;
      end
    end
  end

  assign trc_valid = tv_q;
  assign trc_pc    = pc_q;
  assign trc_addr  = ad_q;
  assign trc_data  = dt_q;

endmodule

// File: doc/grf_mp.md
# grf_mp

Parametrised multi-port general register file for the pipelined CPU datapath: a configurable number of combinational read ports with same-cycle write-through bypass, two prioritised write ports, a per-register busy scoreboard for hazard detection, and a registered commit-trace output that replaces simulation-only printing. It sits in the decode stage: reads and busy queries come from decode, issue marks come from the issue stage, and writes come from the write-back stage(s).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 register 0 is hardwired to zero

- clk  in  1  clock, all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  busy flag for each read address
- we0 / wa0 / wd0 / wpc0  in  1 / ADDR_W / DATA_W / 32  write port 0: enable, address, data, committing PC
- we1 / wa1 / wd1 / wpc1  in  1 / ADDR_W / DATA_W / 32  write port 1, same fields; port 1 has priority
- iss_valid / iss_addr  in  1 / ADDR_W  mark destination register busy
- trc_valid  out  2  per-port commit trace valid, bit p is write port p
- trc_pc  out  64  committing PC; bits [p*32 +: 32]
- trc_addr  out  2*ADDR_W  committed address per port
- trc_data  out  2*DATA_W  committed data per port

## Operation
- Storage: 2**ADDR_W words of DATA_W bits, plus 2**ADDR_W busy bits.
- Effective write on port p: wep=1 and (ZERO_REG=0 or wap≠0).
- Both ports effective to the same address: port 1 data is stored. Both trace lanes still report their own write.
- Read k:
  - If ZERO_REG and rd_addr=0: returns 0.
  - Else if port 1 is effectively writing rd_addr: returns wd1.
  - Else if port 0 is effectively writing rd_addr: returns wd0.
  - Else: returns the stored word.
- rd_busy[k]:
  - Always 0 for address 0 when ZERO_REG=1.
  - Otherwise the stored busy bit AND NOT (an effective write to that address this cycle).
- Busy update at posedge, per address:
  - Set if iss_valid and iss_addr matches.
  - Else cleared if an effective write on either port targets it.
  - A simultaneous issue and write to the same address leaves the bit set, because a new producer is outstanding.
  - An issue to address 0 is ignored when ZERO_REG=1.
- Trace: at posedge, trc_valid[p] <= effective write on port p, and trc_pc/addr/data lane p capture that port's inputs.
  - Trace lanes hold their last value when not valid.
  - Writes to address 0 (ZERO_REG=1) produce no trace.

## Timing
- Reset (reset_n low, asynchronous, no clock needed):
  - All registers and busy bits go to 0.
  - trc_valid = 0; trc_pc, trc_addr and trc_data = 0.
  - rd_data and rd_busy follow combinationally from the cleared state.
- Reset asserted mid-operation discards any in-flight write or issue. The first edge after reset_n rises behaves normally.
- Read latency is 0 cycles (combinational).
- Write becomes visible in storage after 1 edge. The bypass makes it visible to reads in the same cycle.
- Busy is set 1 edge after an issue.
- Trace appears 1 edge after a write and is valid for exactly 1 cycle per write.
- No back-pressure; every input is sampled every cycle.

## Structure
- Shared package grf_pkg holds:
  - default DATA_W and ADDR_W constants;
  - the ZERO_ADDR constant;
  - the trace record typedef (valid, pc, addr, data).
- Sub-module grf_scoreboard holds the busy-bit array, the issue/clear priority logic and the busy lookup with write masking. The parent instantiates it once.

## Test plan
- Reset: write 0x1234 to r5, then pulse reset_n low between edges → r5 reads 0 immediately; trc_valid=0; all rd_busy=0.
- Bypass and priority: same cycle, we0 r3=0xAAAA_0000 and we1 r3=0x5555_FFFF, with rd_addr0=3:
  - same cycle: rd_data0=0x5555_FFFF;
  - next cycle: stored value is 0x5555_FFFF;
  - both trc_valid bits are 1, with the correct per-lane pc/addr/data.
- Zero register: we1 r0=0xFFFF_FFFF with iss_addr=0 → rd_data for r0=0, rd_busy=0, trc_valid[1]=0.
- Scoreboard:
  - issue r7 → next cycle rd_busy=1;
  - we0 r7 in a later cycle → rd_busy=0 in that same cycle, and stays 0 afterwards;
  - issue r7 and we0 r7 in the same cycle → busy remains 1.
- Parameter sweep with NUM_RD=4, ADDR_W=3, DATA_W=16: random writes checked against a reference model over 1000 cycles, covering all read ports, bypass and wrap of the 8-entry depth.
